// File: rtl/aftab_seq_multiplier.sv
// aftab_seq_multiplier: multi-cycle radix-2 shift-add multiplier for the AFTAB datapath.
// Operands are reduced to magnitudes, multiplied over `size` CALC cycles, and the
// product sign is restored in a single FIX cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   startMul   start request, sampled only in IDLE
//   signedA/B  1 = corresponding operand is two's complement
//   a, b       multiplicand / multiplier, sampled on the accepting edge
//   busy       high while an operation is in flight
//   doneMul    one-cycle pulse, products valid from this cycle
//   productLo  low half of the 2*size product (MUL)
//   productHi  high half of the 2*size product (MULH/MULHSU/MULHU)
module aftab_seq_multiplier #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            startMul,
    input  logic            signedA,
    input  logic            signedB,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic            busy,
    output logic            doneMul,
    output logic [size-1:0] productLo,
    output logic [size-1:0] productHi
);

    localparam int unsigned CNT_W  = (size > 1) ? $clog2(size) : 1;
    localparam int unsigned PROD_W = 2 * size;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(size - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [size-1:0]     r_mag_a;
    logic [size-1:0]     r_acc;
    logic [size-1:0]     r_mplr;
    logic                r_neg;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_neg_a;
    logic                w_neg_b;
    logic [size-1:0]     w_mag_a;
    logic [size-1:0]     w_mag_b;
    logic [size:0]       w_sum;
    logic [PROD_W-1:0]   w_prod;
    logic [PROD_W-1:0]   w_result;

    // Operand magnitudes; the most-negative value maps onto itself as an unsigned magnitude.
    assign w_neg_a = signedA & a[size-1];
    assign w_neg_b = signedB & b[size-1];
    assign w_mag_a = w_neg_a ? (~a + size'(1)) : a;
    assign w_mag_b = w_neg_b ? (~b + size'(1)) : b;

    // One shift-add step; the carry out is kept and shifted into the accumulator MSB.
    assign w_sum    = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mag_a} : {(size+1){1'b0}});

    // Accumulator upper half and the consumed multiplier register form the full product.
    assign w_prod   = {r_acc, r_mplr};
    assign w_result = r_neg ? (~w_prod + PROD_W'(1)) : w_prod;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (startMul) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_LAST) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mag_a   <= '0;
            r_acc     <= '0;
            r_mplr    <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            doneMul   <= 1'b0;
            productLo <= '0;
            productHi <= '0;
        end else begin
            doneMul <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (startMul) begin
                        r_mag_a <= w_mag_a;
                        r_mplr  <= w_mag_b;
                        r_acc   <= '0;
                        r_neg   <= w_neg_a ^ w_neg_b;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_acc  <= w_sum[size:1];
                    r_mplr <= {w_sum[0], r_mplr[size-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    productHi <= w_result[PROD_W-1:size];
                    productLo <= w_result[size-1:0];
                    doneMul   <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_seq_multiplier.sv
// tb_aftab_seq_multiplier: directed self-checking bench for aftab_seq_multiplier.
// Drives hand-computed operand pairs and checks latency, busy/doneMul behaviour,
// product hold during CALC, and reset abort.
module tb_aftab_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        startMul;
    logic        signedA;
    logic        signedB;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        doneMul;
    logic [31:0] productLo;
    logic [31:0] productHi;

    int errors = 0;
    int checks = 0;

    // Products expected to be visible before the next FIX edge.
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    aftab_seq_multiplier #(.size(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .startMul  (startMul),
        .signedA   (signedA),
        .signedB   (signedB),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .doneMul   (doneMul),
        .productLo (productLo),
        .productHi (productHi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation (caller is #1 past an edge) and runs it to doneMul.
    // If inj > 0, a start pulse with junk operands is presented while busy.
    task automatic op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                      input logic sa, input logic sb,
                      input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int inj);
        int  lat;
        bit  busy_ok;
        bit  held_ok;
        lat     = 0;
        busy_ok = 1'b1;
        held_ok = 1'b1;
        a        = va;
        b        = vb;
        signedA  = sa;
        signedB  = sb;
        startMul = 1'b1;
        @(posedge clk); #1;
        startMul = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (inj > 0 && n == inj) begin
                startMul = 1'b1;
                a        = 32'd100;
                b        = 32'd100;
                signedA  = 1'b0;
                signedB  = 1'b0;
            end else if (inj > 0 && n == inj + 1) begin
                startMul = 1'b0;
            end
            if (doneMul) begin
                lat = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (productHi !== prev_hi || productLo !== prev_lo) held_ok = 1'b0;
        end
        startMul = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
        chk({tag, "_hold_during"}, 64'(held_ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(productHi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(productLo), 64'(exp_lo));
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    // One edge after doneMul: pulse must fall, products must hold.
    task automatic after_done(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 64'(doneMul), 64'd0);
        chk({tag, "_hold_after"}, {productHi, productLo}, {prev_hi, prev_lo});
    endtask

    initial begin
        int ndone;
        rst      = 1'b0;
        startMul = 1'b0;
        signedA  = 1'b0;
        signedB  = 1'b0;
        a        = '0;
        b        = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(doneMul), 64'd0);
        chk("rst_prod", {productHi, productLo}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Unsigned basic and range extremes.
        op("u7x6", 32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'h0000002A, 0);
        after_done("u7x6");
        op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001, 0);
        after_done("umax");
        op("sm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 32'h1, 0);
        after_done("sm1");
        op("mulhsu", 32'hFFFFFFFD, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        after_done("mulhsu");
        op("minss", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h0, 0);
        after_done("minss");
        op("minuu", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h40000000, 32'h0, 0);
        after_done("minuu");
        op("negzero", 32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, 32'h0, 32'h0, 0);
        after_done("negzero");

        // Start while busy is ignored, then back-to-back start in the doneMul cycle.
        op("ignore", 32'd5, 32'd9, 1'b0, 1'b0, 32'h0, 32'h0000002D, 10);
        op("b2b", 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        after_done("b2b");

        // Reset in the middle of an operation aborts it.
        a        = 32'd11;
        b        = 32'd13;
        signedA  = 1'b0;
        signedB  = 1'b0;
        startMul = 1'b1;
        @(posedge clk); #1;
        startMul = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(doneMul), 64'd0);
        chk("midrst_prod", {productHi, productLo}, 64'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (doneMul) ndone++;
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        op("postrst", 32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'h0000002A, 0);
        after_done("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
